// File: rtl/ftdi_tx_arb_if.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arb_if
// Handshake bundle between two byte-stream sources, the transmit arbiter and
// the FTDI transmit inport.
//   ch0_* / ch1_*   : per-channel valid, data, last (into arbiter), accept (out)
//   outport_*       : valid, data (out of arbiter), accept (into arbiter)
// Modports:
//   slave  - the arbiter's view (consumes channel requests, drives the outport)
//   master - the environment's view (drives channels and FTDI accept)
// ---------------------------------------------------------------------------
interface ftdi_tx_arb_if;
  logic       ch0_valid_i;
  logic [7:0] ch0_data_i;
  logic       ch0_last_i;
  logic       ch0_accept_o;
  logic       ch1_valid_i;
  logic [7:0] ch1_data_i;
  logic       ch1_last_i;
  logic       ch1_accept_o;
  logic       outport_valid_o;
  logic [7:0] outport_data_o;
  logic       outport_accept_i;

  modport slave (
    input  ch0_valid_i, ch0_data_i, ch0_last_i,
    output ch0_accept_o,
    input  ch1_valid_i, ch1_data_i, ch1_last_i,
    output ch1_accept_o,
    output outport_valid_o, outport_data_o,
    input  outport_accept_i
  );

  modport master (
    output ch0_valid_i, ch0_data_i, ch0_last_i,
    input  ch0_accept_o,
    output ch1_valid_i, ch1_data_i, ch1_last_i,
    input  ch1_accept_o,
    input  outport_valid_o, outport_data_o,
    output outport_accept_i
  );
endinterface

// File: rtl/ftdi_tx_arb.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arb
// Two-channel packet arbiter in front of the FTDI transmit inport. A channel
// wins the port for a whole packet (optionally preceded by a channel header
// byte) and keeps it until its last byte transfers. Round-robin between
// packets; channel 0 wins the first contention after reset.
// Parameters:
//   HDR_EN   - 1: send HDR_BASE|channel before each packet, 0: no header
//   HDR_BASE - header byte base value
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   bus      - ftdi_tx_arb_if.slave (channel requests + FTDI outport)
//   grant_o  - one-hot owning channel, 2'b00 when idle
//   busy_o   - packet in progress
// ---------------------------------------------------------------------------
module ftdi_tx_arb #(
  parameter bit         HDR_EN   = 1'b1,
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ftdi_tx_arb_if.slave       bus,
  output logic [1:0]         grant_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e     state_r, state_s;
  logic [1:0] grant_r, grant_s;
  logic       last_r,  last_s;     // last-served channel index (last_q)

  logic       sel_ch_s;            // index of the granted channel
  logic       sel_valid_s;
  logic [7:0] sel_data_s;
  logic       sel_last_s;
  logic       pick_s;              // channel chosen when leaving IDLE

  logic       out_valid_s;
  logic [7:0] out_data_s;
  logic       acc0_s;
  logic       acc1_s;

  // Mux the granted channel's request and pick the next winner.
  always_comb begin
    sel_ch_s = grant_r[1];
    if (sel_ch_s) begin
      sel_valid_s = bus.ch1_valid_i;
      sel_data_s  = bus.ch1_data_i;
      sel_last_s  = bus.ch1_last_i;
    end else begin
      sel_valid_s = bus.ch0_valid_i;
      sel_data_s  = bus.ch0_data_i;
      sel_last_s  = bus.ch0_last_i;
    end
    // With both requesting, the channel not served last wins; otherwise the
    // only requester wins (ch1_valid_i alone selects channel 1).
    if (bus.ch0_valid_i && bus.ch1_valid_i) begin
      pick_s = ~last_r;
    end else begin
      pick_s = bus.ch1_valid_i;
    end
  end

  // Next-state, grant and outport/accept decode.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    last_s      = last_r;
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    acc0_s      = 1'b0;
    acc1_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ch0_valid_i || bus.ch1_valid_i) begin
          grant_s = pick_s ? 2'b10 : 2'b01;
          state_s = HDR_EN ? ST_HDR : ST_DATA;
        end else begin
          grant_s = 2'b00;
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        out_valid_s = 1'b1;
        out_data_s  = HDR_BASE | {7'b0000000, sel_ch_s};
        if (bus.outport_accept_i) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        // Zero-latency pass-through; data forced to zero while not valid.
        out_valid_s = sel_valid_s;
        out_data_s  = sel_valid_s ? sel_data_s : 8'h00;
        acc0_s      = ~sel_ch_s & bus.outport_accept_i;
        acc1_s      =  sel_ch_s & bus.outport_accept_i;
        // A valid gap keeps the grant; only a transferred last byte ends it.
        if (sel_valid_s && bus.outport_accept_i && sel_last_s) begin
          state_s = ST_IDLE;
          grant_s = 2'b00;
          last_s  = sel_ch_s;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // State, grant and last-served pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      grant_r <= 2'b00;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
    end
  end

  // Drive interface and status outputs.
  always_comb begin
    bus.outport_valid_o = out_valid_s;
    bus.outport_data_o  = out_data_s;
    bus.ch0_accept_o    = acc0_s;
    bus.ch1_accept_o    = acc1_s;
    grant_o             = grant_r;
    busy_o              = (state_r != ST_IDLE);
  end

endmodule

// File: tb/tb_ftdi_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_ftdi_tx_arb
// Two instances (with and without header) driven by per-channel packet
// queues, compared every cycle against a packet-ownership reference model,
// plus directed packet scenarios with fixed expected byte streams.
// ---------------------------------------------------------------------------
module tb_ftdi_tx_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ftdi_tx_arb_if ifc_h ();
  ftdi_tx_arb_if ifc_n ();
  logic [1:0] grant_h, grant_n;
  logic       busy_h, busy_n;

  ftdi_tx_arb #(.HDR_EN(1'b1), .HDR_BASE(8'hA0)) dut_h (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifc_h), .grant_o(grant_h), .busy_o(busy_h));
  ftdi_tx_arb #(.HDR_EN(1'b0), .HDR_BASE(8'hA0)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifc_n), .grant_o(grant_n), .busy_o(busy_n));

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus per instance k and channel c
  logic       cv [2][2];
  logic [7:0] cd [2][2];
  logic       cl [2][2];
  logic       oa [2];
  bit         msk [2][2];
  // observed outputs
  logic       ov [2];
  logic [7:0] od [2];
  logic       oc0 [2];
  logic       oc1 [2];
  logic [1:0] og [2];
  logic       ob [2];
  // reference model: owner channel (-1 idle), last served, header owed
  int         own [2];
  int         prv [2];
  bit         owed [2];
  // packet queues {last,data} and captured transfers {grant,data}
  logic [8:0] q00[$], q01[$], q10[$], q11[$];
  logic [9:0] cap0[$], cap1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qsize(input int k, input int c);
    case (k * 2 + c)
      0: return q00.size();
      1: return q01.size();
      2: return q10.size();
      3: return q11.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] qfront(input int k, input int c);
    case (k * 2 + c)
      0: return q00[0];
      1: return q01[0];
      2: return q10[0];
      3: return q11[0];
      default: return 9'h000;
    endcase
  endfunction

  task automatic qpop(input int k, input int c);
    case (k * 2 + c)
      0: void'(q00.pop_front());
      1: void'(q01.pop_front());
      2: void'(q10.pop_front());
      3: void'(q11.pop_front());
      default: ;
    endcase
  endtask

  task automatic qpush(input int k, input int c, input logic [8:0] v);
    case (k * 2 + c)
      0: q00.push_back(v);
      1: q01.push_back(v);
      2: q10.push_back(v);
      3: q11.push_back(v);
      default: ;
    endcase
  endtask

  task automatic flush_all();
    q00.delete(); q01.delete(); q10.delete(); q11.delete();
    for (int k = 0; k < 2; k++) begin
      oa[k] = 1'b0;
      for (int c = 0; c < 2; c++) msk[k][c] = 1'b0;
    end
  endtask

  task automatic apply_inputs();
    ifc_h.ch0_valid_i = cv[0][0]; ifc_h.ch0_data_i = cd[0][0]; ifc_h.ch0_last_i = cl[0][0];
    ifc_h.ch1_valid_i = cv[0][1]; ifc_h.ch1_data_i = cd[0][1]; ifc_h.ch1_last_i = cl[0][1];
    ifc_h.outport_accept_i = oa[0];
    ifc_n.ch0_valid_i = cv[1][0]; ifc_n.ch0_data_i = cd[1][0]; ifc_n.ch0_last_i = cl[1][0];
    ifc_n.ch1_valid_i = cv[1][1]; ifc_n.ch1_data_i = cd[1][1]; ifc_n.ch1_last_i = cl[1][1];
    ifc_n.outport_accept_i = oa[1];
  endtask

  task automatic sample();
    ov[0] = ifc_h.outport_valid_o; od[0] = ifc_h.outport_data_o;
    oc0[0] = ifc_h.ch0_accept_o;   oc1[0] = ifc_h.ch1_accept_o;
    og[0] = grant_h;               ob[0] = busy_h;
    ov[1] = ifc_n.outport_valid_o; od[1] = ifc_n.outport_data_o;
    oc0[1] = ifc_n.ch0_accept_o;   oc1[1] = ifc_n.ch1_accept_o;
    og[1] = grant_n;               ob[1] = busy_n;
  endtask

  task automatic model_reset(input int k);
    own[k] = -1; prv[k] = 1; owed[k] = 1'b0;
  endtask

  // Compare instance k against the model, then advance model and queues.
  task automatic check_and_step(input int k);
    logic       ev, ea0, ea1, eb;
    logic [7:0] ed;
    logic [1:0] eg;
    string      p;
    p = (k == 0) ? "hdr" : "nohdr";
    if (!rst_n) model_reset(k);
    ev = 1'b0; ed = 8'h00; ea0 = 1'b0; ea1 = 1'b0;
    if (own[k] >= 0) begin
      if (owed[k]) begin
        ev = 1'b1;
        ed = 8'hA0 | 8'(own[k]);
      end else begin
        ev = cv[k][own[k]];
        ed = ev ? cd[k][own[k]] : 8'h00;
        if (own[k] == 0) ea0 = oa[k];
        else             ea1 = oa[k];
      end
    end
    eg = (own[k] < 0) ? 2'b00 : ((own[k] == 0) ? 2'b01 : 2'b10);
    eb = (own[k] >= 0);
    chk($sformatf("%s_valid", p), 32'(ov[k]), 32'(ev));
    chk($sformatf("%s_data", p), 32'(od[k]), 32'(ed));
    chk($sformatf("%s_acc0", p), 32'(oc0[k]), 32'(ea0));
    chk($sformatf("%s_acc1", p), 32'(oc1[k]), 32'(ea1));
    chk($sformatf("%s_grant", p), 32'(og[k]), 32'(eg));
    chk($sformatf("%s_busy", p), 32'(ob[k]), 32'(eb));
    if (rst_n && ov[k] && oa[k]) begin
      if (k == 0) cap0.push_back({og[k], od[k]});
      else        cap1.push_back({og[k], od[k]});
    end
    if (rst_n) begin
      if (own[k] < 0) begin
        if (cv[k][0] || cv[k][1]) begin
          own[k]  = (cv[k][0] && cv[k][1]) ? (1 - prv[k]) : (cv[k][0] ? 0 : 1);
          owed[k] = (k == 0);
        end
      end else if (owed[k]) begin
        if (oa[k]) owed[k] = 1'b0;
      end else if (cv[k][own[k]] && oa[k]) begin
        qpop(k, own[k]);
        if (cl[k][own[k]]) begin
          prv[k] = own[k];
          own[k] = -1;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (qsize(k, c) > 0 && msk[k][c]) begin
          cv[k][c] = 1'b1;
          {cl[k][c], cd[k][c]} = qfront(k, c);
        end else begin
          cv[k][c] = 1'b0;
          cd[k][c] = 8'($urandom);
          cl[k][c] = 1'($urandom);
        end
      end
    end
    apply_inputs();
    #1;
    sample();
    for (int k = 0; k < 2; k++) check_and_step(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_all();
    tick();
    tick();
    cap0.delete();
    cap1.delete();
  endtask

  logic [7:0] b [6];
  int         n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      oa[k] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        cv[k][c] = 1'b0; cd[k][c] = 8'h00; cl[k][c] = 1'b0; msk[k][c] = 1'b0;
      end
    end
    apply_inputs();

    // reset state
    do_reset();
    chk("rst_grant", 32'(og[0]), 32'h0);
    chk("rst_busy", 32'(ob[0]), 32'h0);
    chk("rst_valid", 32'(ov[0]), 32'h0);

    // both channels request from reset, 1-byte packets
    qpush(0, 0, {1'b1, 8'h11});
    qpush(0, 1, {1'b1, 8'h22});
    msk[0][0] = 1'b1; msk[0][1] = 1'b1; oa[0] = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 30 && cap0.size() < 4; i++) tick();
    chk("r028_len", 32'(cap0.size()), 32'd4);
    if (cap0.size() == 4) begin
      chk("r028_b0", 32'(cap0[0]), 32'({2'b01, 8'hA0}));
      chk("r028_b1", 32'(cap0[1]), 32'({2'b01, 8'h11}));
      chk("r028_b2", 32'(cap0[2]), 32'({2'b10, 8'hA1}));
      chk("r028_b3", 32'(cap0[3]), 32'({2'b10, 8'h22}));
    end

    // ch0 continuous, 2-byte packets, header each, one idle cycle between
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      qpush(0, 0, {1'(i % 2 == 1), b[i]});
    end
    msk[0][0] = 1'b1; oa[0] = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (cap0.size() < 9 && n < 40) begin
      tick();
      n++;
    end
    chk("r029_cycles", 32'(n), 32'd12);
    if (cap0.size() == 9) begin
      for (int pk = 0; pk < 3; pk++) begin
        chk($sformatf("r029_h%0d", pk), 32'(cap0[3*pk]), 32'({2'b01, 8'hA0}));
        chk($sformatf("r029_d%0d", 2*pk), 32'(cap0[3*pk+1]), 32'({2'b01, b[2*pk]}));
        chk($sformatf("r029_d%0d", 2*pk+1), 32'(cap0[3*pk+2]), 32'({2'b01, b[2*pk+1]}));
      end
    end

    // no header, ch1 3-byte packet, accept toggling
    do_reset();
    qpush(1, 1, {1'b0, 8'h33});
    qpush(1, 1, {1'b0, 8'h44});
    qpush(1, 1, {1'b1, 8'h55});
    msk[1][1] = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && cap1.size() < 3; i++) begin
      oa[1] = (i % 2 == 0);
      tick();
    end
    chk("r030_len", 32'(cap1.size()), 32'd3);
    if (cap1.size() == 3) begin
      chk("r030_b0", 32'(cap1[0]), 32'({2'b10, 8'h33}));
      chk("r030_b1", 32'(cap1[1]), 32'({2'b10, 8'h44}));
      chk("r030_b2", 32'(cap1[2]), 32'({2'b10, 8'h55}));
    end
    tick();
    chk("r030_busy_after", 32'(ob[1]), 32'h0);

    // ch0 valid gap mid-packet while ch1 requests
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      qpush(0, 0, {1'(i == 3), b[i]});
    end
    b[4] = 8'($urandom);
    qpush(0, 1, {1'b1, b[4]});
    msk[0][0] = 1'b1; msk[0][1] = 1'b1; oa[0] = 1'b1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    msk[0][0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("r031_grant%0d", i), 32'(og[0]), 32'h1);
      chk($sformatf("r031_acc1_%0d", i), 32'(oc1[0]), 32'h0);
      chk($sformatf("r031_valid%0d", i), 32'(ov[0]), 32'h0);
    end
    msk[0][0] = 1'b1;
    for (int i = 0; i < 30 && cap0.size() < 7; i++) tick();
    chk("r031_len", 32'(cap0.size()), 32'd7);
    if (cap0.size() == 7) begin
      chk("r031_h0", 32'(cap0[0]), 32'({2'b01, 8'hA0}));
      for (int i = 0; i < 4; i++)
        chk($sformatf("r031_d%0d", i), 32'(cap0[i+1]), 32'({2'b01, b[i]}));
      chk("r031_h1", 32'(cap0[5]), 32'({2'b10, 8'hA1}));
      chk("r031_c0", 32'(cap0[6]), 32'({2'b10, b[4]}));
    end

    // reset during ch1 data byte 2
    do_reset();
    for (int i = 0; i < 3; i++) qpush(0, 1, {1'(i == 2), 8'($urandom)});
    msk[0][1] = 1'b1; oa[0] = 1'b1;
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("r032_pre_grant", 32'(og[0]), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    sample();
    chk("r032_rst_valid", 32'(ov[0]), 32'h0);
    chk("r032_rst_acc1", 32'(oc1[0]), 32'h0);
    chk("r032_rst_grant", 32'(og[0]), 32'h0);
    chk("r032_rst_busy", 32'(ob[0]), 32'h0);
    model_reset(0);
    model_reset(1);
    flush_all();
    tick(); tick();
    cap0.delete();
    qpush(0, 0, {1'b1, 8'h5A});
    qpush(0, 1, {1'b1, 8'hA5});
    msk[0][0] = 1'b1; msk[0][1] = 1'b1; oa[0] = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && cap0.size() < 2; i++) tick();
    chk("r032_len", 32'(cap0.size()), 32'd2);
    if (cap0.size() >= 2) begin
      chk("r032_first_hdr", 32'(cap0[0]), 32'({2'b01, 8'hA0}));
      chk("r032_first_dat", 32'(cap0[1]), 32'({2'b01, 8'h5A}));
    end

    // randomized traffic on both instances
    do_reset();
    rst_n = 1'b1;
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 2; c++) begin
          if (qsize(k, c) == 0 && $urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) qpush(k, c, {1'(i == n - 1), 8'($urandom)});
          end
          msk[k][c] = ($urandom_range(0, 3) != 0);
        end
        oa[k] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
